// File: rtl/escalonador_quantum.sv
// rtl/escalonador_quantum.sv - round-robin process scheduler with per-quantum instruction count
// Saves PCs per slot and issues a one-cycle context-switch pulse with the PC to load.
module escalonador_quantum #(
   parameter int MAX_PROC    = 3,
   parameter int QUANTUM     = 8,
   parameter int QW          = 8,
   parameter int PROC_BASE   = 300,
   parameter int PROC_STRIDE = 300
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    num_proc,
   input  logic          step,
   input  logic [31:0]   pc,
   input  logic          io_req,
   input  logic          fim_proc,
   output logic          troca_contexto,
   output logic [31:0]   pc_contexto,
   output logic [1:0]    processo_atual,
   output logic [QW-1:0] quantum_left,
   output logic          all_done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] SWITCH = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]          state;
   logic [MAX_PROC-1:0] activeMask;
   logic [31:0]         pcTable [MAX_PROC];
   logic [1:0]          nextId;
   logic                nextFound;
   logic [1:0]          numEff;
   logic [1:0]          curSlot;

   assign curSlot = processo_atual - 2'd1;
   assign numEff  = (int'(num_proc) > MAX_PROC) ? 2'(MAX_PROC) : num_proc;

   // Slots above the current id win first; otherwise the lowest active id, which leaves current last.
   always_comb begin
      nextId    = 2'd0;
      nextFound = 1'b0;
      for (int j = 0; j < MAX_PROC; j++) begin
         if (!nextFound && activeMask[j] && (j + 1 > int'(processo_atual))) begin
            nextId    = 2'(j + 1);
            nextFound = 1'b1;
         end
      end
      for (int j = 0; j < MAX_PROC; j++) begin
         if (!nextFound && activeMask[j]) begin
            nextId    = 2'(j + 1);
            nextFound = 1'b1;
         end
      end
   end

   assign troca_contexto = (state == SWITCH) && nextFound && (nextId != processo_atual);
   assign pc_contexto    = troca_contexto ? pcTable[nextId - 2'd1] : 32'd0;
   assign all_done       = (state == DONE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         activeMask     <= '0;
         processo_atual <= 2'd0;
         quantum_left   <= '0;
         for (int j = 0; j < MAX_PROC; j++) pcTable[j] <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int j = 0; j < MAX_PROC; j++) begin
                     pcTable[j]    <= 32'(PROC_BASE + j * PROC_STRIDE);
                     activeMask[j] <= (j < int'(numEff));
                  end
                  processo_atual <= 2'd0;
                  state          <= (numEff == 2'd0) ? DONE : SWITCH;
               end
            end
            RUN: begin
               if (step) begin
                  if (fim_proc) begin
                     activeMask[curSlot] <= 1'b0;
                     state               <= SWITCH;
                  end else if (io_req || quantum_left == QW'(1)) begin
                     pcTable[curSlot] <= pc + 32'd1;
                     state            <= SWITCH;
                  end else begin
                     quantum_left <= quantum_left - QW'(1);
                  end
               end
            end
            SWITCH: begin
               if (!nextFound) begin
                  processo_atual <= 2'd0;
                  state          <= DONE;
               end else begin
                  processo_atual <= nextId;
                  quantum_left   <= QW'(QUANTUM);
                  state          <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_escalonador_quantum.sv
// tb/tb_escalonador_quantum.sv - directed and randomized checks of escalonador_quantum against a behavioural model
// The model tracks phase, saved PCs and live processes; a negedge process compares every cycle.
module tb_escalonador_quantum;

   localparam int MAXP   = 3;
   localparam int Q      = 4;
   localparam int BASE   = 300;
   localparam int STRIDE = 300;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  num_proc = 2'd0;
   logic        step = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        io_req = 1'b0;
   logic        fim_proc = 1'b0;
   logic        troca_contexto;
   logic [31:0] pc_contexto;
   logic [1:0]  processo_atual;
   logic [7:0]  quantum_left;
   logic        all_done;

   int errors = 0;
   int checks = 0;
   bit chk = 1'b0;

   escalonador_quantum #(
      .MAX_PROC(MAXP), .QUANTUM(Q), .QW(8), .PROC_BASE(BASE), .PROC_STRIDE(STRIDE)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .num_proc(num_proc), .step(step), .pc(pc),
      .io_req(io_req), .fim_proc(fim_proc), .troca_contexto(troca_contexto), .pc_contexto(pc_contexto),
      .processo_atual(processo_atual), .quantum_left(quantum_left), .all_done(all_done)
   );

   always #5 clock = ~clock;

   // Model: phase 0 idle, 1 running, 2 switching, 3 done
   int          mPhase = 0;
   int          mCur = 0;
   int          mQ = 0;
   logic [31:0] mPc [1:MAXP];
   bit          mAlive [1:MAXP];

   function automatic int nextOf();
      for (int off = 1; off <= MAXP; off++) begin
         int id;
         id = ((mCur + off - 1) % MAXP) + 1;
         if (mAlive[id]) return id;
      end
      return 0;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mPhase = 0; mCur = 0; mQ = 0;
         for (int k = 1; k <= MAXP; k++) begin mPc[k] = 32'd0; mAlive[k] = 1'b0; end
      end else begin
         case (mPhase)
            0, 3: if (start) begin
               int n;
               n = (int'(num_proc) > MAXP) ? MAXP : int'(num_proc);
               for (int k = 1; k <= MAXP; k++) begin
                  mPc[k]    = 32'(BASE + (k - 1) * STRIDE);
                  mAlive[k] = (k <= n);
               end
               mCur   = 0;
               mPhase = (n == 0) ? 3 : 2;
            end
            1: if (step) begin
               if (fim_proc) begin
                  mAlive[mCur] = 1'b0; mPhase = 2;
               end else if (io_req || mQ == 1) begin
                  mPc[mCur] = pc + 32'd1; mPhase = 2;
               end else begin
                  mQ = mQ - 1;
               end
            end
            default: begin
               int nx;
               nx = nextOf();
               if (nx == 0) begin mCur = 0; mPhase = 3; end
               else begin mCur = nx; mQ = Q; mPhase = 1; end
            end
         endcase
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk) begin
         int  nx;
         bit  eT;
         nx = nextOf();
         eT = (mPhase == 2) && (nx != 0) && (nx != mCur);
         check("troca_contexto", 32'(troca_contexto), 32'(eT));
         check("pc_contexto", pc_contexto, eT ? mPc[nx] : 32'd0);
         check("processo_atual", 32'(processo_atual), 32'(mCur));
         check("quantum_left", 32'(quantum_left), 32'(mQ));
         check("all_done", 32'(all_done), 32'(mPhase == 3));
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic doStep(input logic [31:0] p, input logic io, input logic fim);
      step = 1'b1; pc = p; io_req = io; fim_proc = fim;
      tick();
      step = 1'b0; io_req = 1'b0; fim_proc = 1'b0;
   endtask

   task automatic doStart(input logic [1:0] n);
      start = 1'b1; num_proc = n;
      tick();
      start = 1'b0;
   endtask

   initial begin
      chk = 1'b1;
      // Reset and idle
      repeat (3) tick();
      check("reset_troca", 32'(troca_contexto), 32'd0);
      check("reset_id", 32'(processo_atual), 32'd0);
      reset = 1'b1;
      repeat (5) tick();
      check("idle_all_done", 32'(all_done), 32'd0);

      // Two processes, quantum expiry rotation
      doStart(2'd2);
      check("t2_pulse", 32'(troca_contexto), 32'd1);
      check("t2_pc300", pc_contexto, 32'd300);
      tick();
      check("t2_id1", 32'(processo_atual), 32'd1);
      check("t2_q", 32'(quantum_left), 32'd4);
      for (int i = 0; i < 4; i++) doStep(32'(300 + i), 1'b0, 1'b0);
      check("t2_pc600", pc_contexto, 32'd600);
      tick();
      check("t2_id2", 32'(processo_atual), 32'd2);
      for (int i = 0; i < 4; i++) doStep(32'(600 + i), 1'b0, 1'b0);
      check("t2_pc304", pc_contexto, 32'd304);
      tick();

      // IO request switches early and resumes at pc+1
      doStep(32'd304, 1'b0, 1'b0);
      doStep(32'd305, 1'b1, 1'b0);
      check("t3_pc604", pc_contexto, 32'd604);
      tick();
      doStep(32'd604, 1'b1, 1'b0);
      check("t3_pc306", pc_contexto, 32'd306);
      tick();

      // End of processes, then restart
      doStep(32'd306, 1'b1, 1'b0);
      check("t4_pc605", pc_contexto, 32'd605);
      tick();
      doStep(32'd605, 1'b0, 1'b1);
      check("t4_pc307", pc_contexto, 32'd307);
      tick();
      doStep(32'd307, 1'b0, 1'b1);
      check("t4_nopulse", 32'(troca_contexto), 32'd0);
      tick();
      check("t4_done", 32'(all_done), 32'd1);
      check("t4_id0", 32'(processo_atual), 32'd0);
      doStart(2'd2);
      check("t4_restart", pc_contexto, 32'd300);
      tick();
      doStep(32'd300, 1'b0, 1'b1);
      tick();
      doStep(32'd600, 1'b0, 1'b1);
      tick();

      // Sole survivor keeps running; zero processes
      doStart(2'd1);
      tick();
      for (int i = 0; i < 4; i++) doStep(32'(300 + i), 1'b0, 1'b0);
      check("t5_nopulse", 32'(troca_contexto), 32'd0);
      tick();
      check("t5_q", 32'(quantum_left), 32'd4);
      check("t5_id1", 32'(processo_atual), 32'd1);
      doStep(32'd304, 1'b0, 1'b1);
      tick();
      doStart(2'd0);
      check("t5_done0", 32'(all_done), 32'd1);

      // Combined io+fim+expiry, then reset during a switch
      doStart(2'd3);
      tick();
      for (int i = 0; i < 3; i++) doStep(32'(300 + i), 1'b0, 1'b0);
      doStep(32'd303, 1'b1, 1'b1);
      check("t6_pc600", pc_contexto, 32'd600);
      tick();
      doStep(32'd600, 1'b1, 1'b0);
      check("t6_pc900", pc_contexto, 32'd900);
      tick();
      doStep(32'd900, 1'b1, 1'b0);
      check("t6_skip1", pc_contexto, 32'd601);
      tick();
      doStep(32'd601, 1'b1, 1'b0);
      check("t6_pulse", 32'(troca_contexto), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("t6_async", 32'(troca_contexto), 32'd0);
      check("t6_async_pc", pc_contexto, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("t6_idle", 32'(processo_atual), 32'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom % 400) != 0;
         start    = ($urandom % 40) == 0;
         num_proc = 2'($urandom % 4);
         step     = ($urandom % 10) < 7;
         io_req   = ($urandom % 10) == 0;
         fim_proc = ($urandom % 25) == 0;
         pc       = (($urandom % 8) == 0) ? 32'hFFFF_FFFF : $urandom;
         tick();
      end
      reset = 1'b1; start = 1'b0; step = 1'b0; io_req = 1'b0; fim_proc = 1'b0;
      tick();
      chk = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
